load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle data-memory front end that sits downstream of the RV32I datapath.
//  It replaces the single-cycle Memory block's direct access.
//  Takes the ALU address, rs2 store data and funct3, and drives a req/ack data bus with byte enables.
//  Sign/zero-extends loads and holds the core via stall until the access completes.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in BUSY waiting for bus_ack before the access is aborted with bus_err
// PORTS
//  clk          in   1   rising-edge clock
//  reset        in   1   synchronous, active-low reset
//  req_valid    in   1   current instruction is a load/store (MemRead|MemWrite)
//  req_we       in   1   1=store, 0=load
//  funct3       in   3   instr[14:12]: LB/LH/LW/LBU/LHU, SB/SH/SW
//  addr         in   32  byte address (alu_out)
//  wdata        in   32  store data (rs2_output)
//  stall        out  1   freeze PC/RegWrite while high
//  rdata        out  32  extended load result, valid while done=1
//  done         out  1   access finished this cycle; core commits on this edge
//  misalign     out  1   one-cycle pulse: misaligned address or illegal funct3
//  bus_err      out  1   one-cycle pulse with done: access timed out
//  bus_req      out  1   bus request, registered
//  bus_we       out  1   bus write enable
//  bus_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  bus_be       out  4   byte-lane enables
//  bus_wdata    out  32  lane-replicated store data
//  bus_ack      in   1   bus completion, sampled only in BUSY
//  bus_rdata    in   32  read word, valid with bus_ack
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE, timeout counter=0, all outputs 0; a pending access is abandoned.
//  - FSM IDLE->BUSY->DONE->IDLE. Bus outputs are registered and stay stable throughout BUSY.
//  - IDLE with req_valid & legal & aligned:
//      - stall=1 combinationally.
//      - Latch we/be/addr/wdata/funct3; next state BUSY with bus_req=1.
//  - IDLE with req_valid & (misaligned | illegal funct3):
//      - misalign=1, done=1, stall=0, rdata=0, no bus transaction.
//  - Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0.
//  - Illegal funct3: loads 3/6/7; stores >2.
//  - BUSY: stall=1.
//      - bus_ack=1: capture bus_rdata, drop bus_req, go DONE.
//      - Counter reaches TIMEOUT_CYCLES: drop bus_req, go DONE, set bus_err, rdata=0.
//  - DONE: stall=0, done=1 for exactly one cycle; next IDLE.
//      - req_valid seen in this cycle belongs to the finishing instruction and is not re-issued.
//  - Latency: minimum 3 cycles per access (IDLE, BUSY with same-cycle ack, DONE).
//  - bus_ack outside BUSY is ignored.
//  - Lanes, o = addr[1:0]:
//      - SB: be = 4'b0001<<o, wdata replicated x4.
//      - SH: be = addr[1] ? 4'b1100 : 4'b0011, halfword replicated x2.
//      - SW: be = 4'b1111.
//      - Loads drive be=4'b1111.
//  - Load extract: select byte o or halfword addr[1] from bus_rdata.
//      - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
//  - Stores: rdata=0 at done.
// STRUCTURE
//  - Shared package rv32_pkg:
//      - funct3 constants F3_LB..F3_LHU, F3_SB..F3_SW.
//      - lsu_state_t enum {IDLE, BUSY, DONE}.
//  - Sub-module lsu_lane_align (combinational):
//      - Store side: be/wdata replication.
//      - Load side: byte/halfword extract and sign extension.
//      - Alignment check.
//  - Top holds the FSM, timeout counter and bus registers.
// TESTING
//  1. LW addr=0x100, bus_rdata=0xDEADBEEF, ack 1st BUSY cycle:
//     -> bus_be=1111, stall 2 cycles, done cycle 3, rdata=0xDEADBEEF.
//  2. LB addr=0x103, rdata word 0x80FF_0000 -> rdata=0xFFFFFF80.
//     Same with LBU -> 0x00000080.
//  3. SH addr=0x202, wdata=0x1234ABCD:
//     -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, bus_addr=0x200.
//  4. LW addr=0x101 -> misalign=1 and done=1 same cycle, bus_req never asserted, stall=0.
//  5. SW with bus_ack held 0, TIMEOUT_CYCLES=4:
//     -> bus_req drops after 4 BUSY cycles, done+bus_err pulse.
//  6. reset=0 during BUSY -> next cycle bus_req=0, IDLE.
//     Late bus_ack is ignored, no done.

Source files
------------

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared funct3 encodings and load/store unit state type
package rv32_pkg;
  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane steering, load extension and alignment check
module lsu_lane_align
  import rv32_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rword,
  output logic        ok,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rext
);
  logic       legal;
  logic       aligned;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  // request legality, store lanes and load extraction from the latched access
  always_comb begin
    legal   = we ? (funct3 inside {F3_SB, F3_SH, F3_SW})
                 : (funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    aligned = funct3[1:0] == 2'd2 ? off == 2'd0 : funct3[1:0] == 2'd1 ? !off[0] : 1'b1;
    ok      = legal && aligned;
    be      = !we ? 4'b1111 : funct3 == F3_SB ? 4'b0001 << off
            : funct3 == F3_SH ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wlane   = funct3 == F3_SB ? {4{wdata[7:0]}} : funct3 == F3_SH ? {2{wdata[15:0]}} : wdata;
    rbyte   = rword[{ld_off, 3'b000} +: 8];
    rhalf   = ld_off[1] ? rword[31:16] : rword[15:0];
    rext    = ld_funct3 == F3_LB  ? {{24{rbyte[7]}}, rbyte}
            : ld_funct3 == F3_LH  ? {{16{rhalf[15]}}, rhalf}
            : ld_funct3 == F3_LW  ? rword
            : ld_funct3 == F3_LBU ? {24'd0, rbyte}
            : ld_funct3 == F3_LHU ? {16'd0, rhalf} : 32'd0;
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle req/ack data-memory front end with stall and timeout
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  lsu_state_t  state, state_d;
  logic [CW-1:0] cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        ok, start, bad, tmo;
  logic [3:0]  be;
  logic [31:0] wlane, rext;
  lsu_lane_align u_align (
    .we(req_we), .funct3(funct3), .off(addr[1:0]), .wdata(wdata),
    .ld_funct3(f3_q), .ld_off(off_q), .rword(bus_rdata),
    .ok(ok), .be(be), .wlane(wlane), .rext(rext)
  );
  assign start = state == IDLE && req_valid && ok;
  assign bad   = state == IDLE && req_valid && !ok;
  assign tmo   = cnt == CW'(TIMEOUT_CYCLES - 1);
  // state register; reset abandons any in-flight access
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_d;
  // next state: DONE always returns to IDLE so the finishing req_valid is not re-issued
  always_comb
    state_d = state == IDLE ? (start ? BUSY : IDLE)
            : state == BUSY ? ((bus_ack || tmo) ? DONE : BUSY) : IDLE;
  // core-facing outputs; rejected requests complete immediately without a bus cycle
  always_comb begin
    stall    = start || state == BUSY;
    done     = bad || state == DONE;
    misalign = bad;
    bus_err  = state == DONE && err_q;
    rdata    = state == DONE ? rdata_q : 32'd0;
  end
  // bus registers held stable in BUSY, timeout counter and captured load result
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'd0;
      bus_wdata <= 32'd0;
      cnt       <= '0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else if (start) begin
      bus_req   <= 1'b1;
      bus_we    <= req_we;
      bus_addr  <= {addr[31:2], 2'b00};
      bus_be    <= be;
      bus_wdata <= wlane;
      cnt       <= '0;
      f3_q      <= funct3;
      off_q     <= addr[1:0];
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
    end else if (state == BUSY) begin
      bus_req <= !(bus_ack || tmo);
      cnt     <= bus_ack || tmo ? cnt : cnt + 1'b1;
      rdata_q <= bus_ack && !bus_we ? rext : 32'd0;
      err_q   <= !bus_ack && tmo;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of load/store lanes, misalignment, timeout and reset
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_we, bus_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, bus_rdata;
  logic        stall, done, misalign, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  int checks = 0;
  int errors = 0;
  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .done(done),
    .misalign(misalign), .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic access(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                        input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] erd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    #1;
    chk({tag, ".idle_stall"}, 32'(stall), 32'd1);
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
    @(negedge clk);
    chk({tag, ".busy_req"}, 32'(bus_req), 32'd1);
    chk({tag, ".busy_stall"}, 32'(stall), 32'd1);
    chk({tag, ".bus_we"}, 32'(bus_we), 32'(we));
    chk({tag, ".bus_addr"}, bus_addr, {a[31:2], 2'b00});
    chk({tag, ".bus_be"}, 32'(bus_be), 32'(ebe));
    if (we) chk({tag, ".bus_wdata"}, bus_wdata, ewd);
    bus_ack = 1'b1; bus_rdata = word;
    @(negedge clk);
    bus_ack = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".done_stall"}, 32'(stall), 32'd0);
    chk({tag, ".rdata"}, rdata, erd);
    chk({tag, ".done_req"}, 32'(bus_req), 32'd0);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'd0);
    @(negedge clk);
    chk({tag, ".no_reissue"}, 32'(bus_req), 32'd0);
    chk({tag, ".after_done"}, 32'(done), 32'd0);
    req_valid = 1'b0;
  endtask
  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0;
    addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst.bus_req", 32'(bus_req), 32'd0);
    chk("rst.bus_be", 32'(bus_be), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.stall", 32'(stall), 32'd0);
    reset = 1'b1;
    bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("idle_ack.done", 32'(done), 32'd0);
    chk("idle_ack.req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
    access("lw",  1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 4'b1111, 32'd0, 32'hDEADBEEF);
    access("lb",  1'b0, 3'd0, 32'h103, 32'd0, 32'h80FF0000, 4'b1111, 32'd0, 32'hFFFFFF80);
    access("lbu", 1'b0, 3'd4, 32'h103, 32'd0, 32'h80FF0000, 4'b1111, 32'd0, 32'h00000080);
    access("lh",  1'b0, 3'd1, 32'h102, 32'd0, 32'h80011234, 4'b1111, 32'd0, 32'hFFFF8001);
    access("lhu", 1'b0, 3'd5, 32'h100, 32'd0, 32'h80019234, 4'b1111, 32'd0, 32'h00009234);
    access("sh",  1'b1, 3'd1, 32'h202, 32'h1234ABCD, 32'h55555555, 4'b1100, 32'hABCDABCD, 32'd0);
    access("sb",  1'b1, 3'd0, 32'h201, 32'h000000EF, 32'd0, 4'b0010, 32'hEFEFEFEF, 32'd0);
    access("sw",  1'b1, 3'd2, 32'h204, 32'hCAFEF00D, 32'd0, 4'b1111, 32'hCAFEF00D, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd2; addr = 32'h101;
    #1;
    chk("mis_lw.misalign", 32'(misalign), 32'd1);
    chk("mis_lw.done", 32'(done), 32'd1);
    chk("mis_lw.stall", 32'(stall), 32'd0);
    chk("mis_lw.rdata", rdata, 32'd0);
    @(negedge clk);
    chk("mis_lw.no_req", 32'(bus_req), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd3; addr = 32'h300;
    #1;
    chk("ill_st.misalign", 32'(misalign), 32'd1);
    funct3 = 3'd6; req_we = 1'b0;
    #1;
    chk("ill_ld.misalign", 32'(misalign), 32'd1);
    funct3 = 3'd1; addr = 32'h301;
    #1;
    chk("mis_lh.misalign", 32'(misalign), 32'd1);
    @(negedge clk);
    chk("ill.no_req", 32'(bus_req), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; addr = 32'h400; wdata = 32'h11223344;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("tmo.busy%0d_req", i), 32'(bus_req), 32'd1);
      chk($sformatf("tmo.busy%0d_done", i), 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("tmo.done", 32'(done), 32'd1);
    chk("tmo.bus_err", 32'(bus_err), 32'd1);
    chk("tmo.req", 32'(bus_req), 32'd0);
    chk("tmo.rdata", rdata, 32'd0);
    @(negedge clk);
    chk("tmo.err_pulse", 32'(bus_err), 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd2; addr = 32'h500;
    @(negedge clk);
    chk("rst_busy.req", 32'(bus_req), 32'd1);
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy.req_low", 32'(bus_req), 32'd0);
    chk("rst_busy.stall", 32'(stall), 32'd0);
    reset = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h12345678;
    @(negedge clk);
    chk("late_ack.done", 32'(done), 32'd0);
    chk("late_ack.rdata", rdata, 32'd0);
    bus_ack = 1'b0;
    @(negedge clk);
    chk("late_ack.done2", 32'(done), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
